// File: rtl/intctl_pkg.sv
// Shared definitions for the interrupt controller: state encoding, vector stride
// and the handler-address helper.
package intctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2
  } intctl_state_e;

  localparam int VEC_STRIDE = 4;

  // Handler address wraps modulo 2^16 so a base near the top of memory folds to zero.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + idx * 16'(VEC_STRIDE);
  endfunction

endpackage

// File: rtl/intctl_arb.sv
// Combinational winner selection among enabled requests.
// INTCTL_RR_EN selects round-robin (search upward from ptr+1); otherwise lowest index wins.
module intctl_arb
  import intctl_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);

  assign valid = |req;

`ifdef INTCTL_RR_EN
  logic          found;
  logic [IW-1:0] idx;

  // Rotate the search start to just past the last grant so every source gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = IW'((int'(ptr) + k) % NSRC);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end
`endif

endmodule

// File: rtl/interrupt_ctl.sv
// Single-level interrupt controller: IDLE -> ENTER (one-clock take/ack) -> SERVICE until rti.
// Define INTCTL_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module interrupt_ctl
  import intctl_pkg::*;
#(
  parameter int          NSRC     = 4,
  parameter logic [15:0] VEC_BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            nclr,
  input  logic [NSRC-1:0] irq,
  input  logic            cycle,
  input  logic [15:0]     pc,
  input  logic            ei,
  input  logic            di,
  input  logic            rti,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_d,
  output logic            ienabled,
  output logic            istatus,
  output logic [15:0]     intRA,
  output logic            take,
  output logic [15:0]     vector,
  output logic [NSRC-1:0] ack
);

  localparam int IW = $clog2(NSRC);

  intctl_state_e   state, state_next;
  logic [NSRC-1:0] mask;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   winner;
  logic            valid;
  logic            take_now;

`ifdef INTCTL_RR_EN
  logic [IW-1:0] rr_ptr;

  intctl_arb #(.NSRC(NSRC), .IW(IW)) u_arb (
    .req    (irq & mask),
    .ptr    (rr_ptr),
    .valid  (valid),
    .winner (winner)
  );
`else
  intctl_arb #(.NSRC(NSRC), .IW(IW)) u_arb (
    .req    (irq & mask),
    .ptr    ({IW{1'b0}}),
    .valid  (valid),
    .winner (winner)
  );
`endif

  // The old ienabled is used, so an ei on this boundary cannot trigger a take here.
  assign take_now = (state == IDLE) && cycle && ienabled && !di && valid;

  always_ff @(posedge clk) begin
    if (!nclr) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take_now) state_next = ENTER;
      ENTER:   state_next = SERVICE;
      SERVICE: if (cycle && rti) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    istatus = (state != IDLE);
    take    = (state == ENTER);
    ack     = '0;
    if (state == ENTER) ack[grant] = 1'b1;
  end

  // Grant index and vector are captured at the boundary so later irq changes cannot disturb them.
  always_ff @(posedge clk) begin
    if (!nclr) begin
      ienabled <= 1'b0;
      mask     <= '1;
      intRA    <= '0;
      vector   <= VEC_BASE;
      grant    <= '0;
`ifdef INTCTL_RR_EN
      rr_ptr   <= IW'(NSRC - 1);
`endif
    end else begin
      if (cycle && di)      ienabled <= 1'b0;
      else if (cycle && ei) ienabled <= 1'b1;
      if (mask_wr) mask <= mask_d;
      if ((state == IDLE) && cycle && ienabled) intRA <= pc;
      if (take_now) begin
        grant  <= winner;
        vector <= vec_addr(VEC_BASE, 16'(winner));
`ifdef INTCTL_RR_EN
        rr_ptr <= winner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_interrupt_ctl.sv
// Self-checking bench for interrupt_ctl: directed scenarios then random traffic,
// every clock compared against a behavioural model; works with or without INTCTL_RR_EN.
module tb_interrupt_ctl;

  localparam int NSRC = 4;
`ifdef INTCTL_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nclr, cycle, ei, di, rti, mask_wr;
  logic [NSRC-1:0] irq, mask_d;
  logic [15:0]     pc;
  logic            ienabled, istatus, take;
  logic [15:0]     intRA, vector;
  logic [NSRC-1:0] ack;
  logic            ienabled_b, istatus_b, take_b;
  logic [15:0]     intRA_b, vector_b;
  logic [NSRC-1:0] ack_b;

  int n_vec = 0;
  int n_err = 0;

  // Model: handler flag, entry flag, enable, mask, return address, last winner, rr pointer.
  bit              m_in_handler, m_entering, m_ien;
  bit [NSRC-1:0]   m_mask;
  bit [15:0]       m_ra;
  int              m_idx, m_ptr;

  always #5 clk = ~clk;

  interrupt_ctl #(.NSRC(NSRC), .VEC_BASE(16'hFF00)) dut (
    .clk(clk), .nclr(nclr), .irq(irq), .cycle(cycle), .pc(pc),
    .ei(ei), .di(di), .rti(rti), .mask_wr(mask_wr), .mask_d(mask_d),
    .ienabled(ienabled), .istatus(istatus), .intRA(intRA),
    .take(take), .vector(vector), .ack(ack)
  );

  interrupt_ctl #(.NSRC(NSRC), .VEC_BASE(16'hFFFC)) dut_b (
    .clk(clk), .nclr(nclr), .irq(irq), .cycle(cycle), .pc(pc),
    .ei(ei), .di(di), .rti(rti), .mask_wr(mask_wr), .mask_d(mask_d),
    .ienabled(ienabled_b), .istatus(istatus_b), .intRA(intRA_b),
    .take(take_b), .vector(vector_b), .ack(ack_b)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input bit [NSRC-1:0] r, input int p);
    int start;
    start = RR_MODE ? (p + 1) % NSRC : 0;
    for (int k = 0; k < NSRC; k++)
      if (r[(start + k) % NSRC]) return (start + k) % NSRC;
    return -1;
  endfunction

  task automatic modelEdge();
    bit go;
    if (!nclr) begin
      m_in_handler = 0; m_entering = 0; m_ien = 0;
      m_mask = '1; m_ra = 0; m_idx = 0; m_ptr = NSRC - 1;
    end else begin
      go = !m_in_handler && cycle && m_ien && !di && ((irq & m_mask) != 0);
      if (!m_in_handler && cycle && m_ien) m_ra = pc;
      if (m_entering) m_entering = 0;
      else if (m_in_handler && cycle && rti) m_in_handler = 0;
      if (go) begin
        m_idx = pick(irq & m_mask, m_ptr);
        m_ptr = m_idx;
        m_entering = 1;
        m_in_handler = 1;
      end
      if (cycle && di)      m_ien = 0;
      else if (cycle && ei) m_ien = 1;
      if (mask_wr) m_mask = mask_d;
    end
  endtask

  task automatic compareAll();
    logic [NSRC-1:0] exp_ack;
    exp_ack = m_entering ? NSRC'(1 << m_idx) : '0;
    checkOutput("take",     16'(take),     16'(m_entering));
    checkOutput("ack",      16'(ack),      16'(exp_ack));
    checkOutput("istatus",  16'(istatus),  16'(m_in_handler));
    checkOutput("ienabled", 16'(ienabled), 16'(m_ien));
    checkOutput("intRA",    intRA,         m_ra);
    checkOutput("vector",   vector,        16'(32'hFF00 + m_idx * 4));
    checkOutput("vector_b", vector_b,      16'(32'hFFFC + m_idx * 4));
  endtask

  task automatic applyStimulus(input logic n, input logic c, input logic [15:0] p,
                               input logic [NSRC-1:0] i, input logic e, input logic d,
                               input logic r, input logic mw = 1'b0,
                               input logic [NSRC-1:0] md = '0);
    nclr = n; cycle = c; pc = p; irq = i; ei = e; di = d; rti = r;
    mask_wr = mw; mask_d = md;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  initial begin
    nclr = 0; cycle = 0; pc = 0; irq = 0; ei = 0; di = 0; rti = 0; mask_wr = 0; mask_d = 0;

    applyStimulus(0, 0, 16'h0000, 4'b0000, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 4'b0000, 0, 0, 0);
    checkOutput("rst_vector", vector, 16'hFF00);
    checkOutput("rst_ien", 16'(ienabled), 16'h0);

    // Request while disabled, then ei boundary (no take yet), then the take.
    applyStimulus(1, 1, 16'h1111, 4'b0100, 0, 0, 0);
    checkOutput("dis_take", 16'(take), 16'h0);
    applyStimulus(1, 1, 16'h2222, 4'b0100, 1, 0, 0);
    checkOutput("ei_same_take", 16'(take), 16'h0);
    applyStimulus(1, 1, 16'h1234, 4'b0100, 0, 0, 0);
    checkOutput("t1_take", 16'(take), 16'h1);
    checkOutput("t1_ack", 16'(ack), 16'h0004);
    checkOutput("t1_vec", vector, 16'hFF08);
    checkOutput("t1_ra", intRA, 16'h1234);
    checkOutput("t1_ist", 16'(istatus), 16'h1);

    // No nesting while in service; rti returns, next boundary grants source 0.
    applyStimulus(1, 0, 16'h0000, 4'b0001, 0, 0, 0);
    applyStimulus(1, 1, 16'h3000, 4'b0001, 0, 0, 0);
    checkOutput("nest_take", 16'(take), 16'h0);
    applyStimulus(1, 1, 16'h3004, 4'b0001, 0, 0, 1);
    checkOutput("rti_ist", 16'(istatus), 16'h0);
    applyStimulus(1, 1, 16'h3008, 4'b0001, 0, 0, 0);
    checkOutput("t2_ack", 16'(ack), 16'h0001);
    checkOutput("t2_vec", vector, 16'hFF00);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0);
    applyStimulus(1, 1, 16'h4000, 4'b0000, 0, 0, 1);

    // Two requesters: first grant is source 1 in both modes; then modes diverge.
    applyStimulus(1, 1, 16'h5000, 4'b1010, 0, 0, 0);
    checkOutput("t3_ack", 16'(ack), 16'h0002);
    checkOutput("t3_vec", vector, 16'hFF04);
    checkOutput("t3_vec_wrap", vector_b, 16'h0000);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0);
    applyStimulus(1, 1, 16'h5100, 4'b0000, 0, 0, 1);
    applyStimulus(1, 1, 16'h6000, 4'b1010, 0, 0, 0);
    checkOutput("t4_ack", 16'(ack), RR_MODE ? 16'h0008 : 16'h0002);
    checkOutput("t4_vec", vector, RR_MODE ? 16'hFF0C : 16'hFF04);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0);
    applyStimulus(1, 1, 16'h6100, 4'b0000, 0, 0, 1);

    // di wins on a request boundary; masked source cannot be taken.
    applyStimulus(1, 1, 16'h7000, 4'b0001, 0, 1, 0);
    checkOutput("di_take", 16'(take), 16'h0);
    checkOutput("di_ien", 16'(ienabled), 16'h0);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0, 1'b1, 4'b1110);
    applyStimulus(1, 1, 16'h7100, 4'b0000, 1, 0, 0);
    applyStimulus(1, 1, 16'h7200, 4'b0001, 0, 0, 0);
    checkOutput("mask_take", 16'(take), 16'h0);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0, 1'b1, 4'b1111);

    // Reset mid-handler.
    applyStimulus(1, 1, 16'h8000, 4'b0010, 0, 0, 0);
    applyStimulus(1, 0, 16'h0000, 4'b0000, 0, 0, 0);
    checkOutput("svc_ist", 16'(istatus), 16'h1);
    applyStimulus(0, 1, 16'h9000, 4'b0010, 1, 0, 0);
    checkOutput("rst2_ist", 16'(istatus), 16'h0);
    checkOutput("rst2_ra", intRA, 16'h0000);
    checkOutput("rst2_vec", vector, 16'hFF00);
    checkOutput("rst2_ien", 16'(ienabled), 16'h0);
    applyStimulus(1, 1, 16'h9100, 4'b0001, 1, 0, 0);
    checkOutput("post_rst_take", 16'(take), 16'h0);
    applyStimulus(1, 1, 16'h9200, 4'b0001, 0, 0, 0);
    checkOutput("mask_rst_ack", 16'(ack), 16'h0001);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                    16'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
                    4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_ctl.md
INTERRUPT_CTL -- requirements
Module: interrupt_ctl

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of interrupt requesters (2..8).
REQ-002 SHALL have parameter VEC_BASE, default 16'hFF00, address of the first handler vector.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nclr  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port irq  input  NSRC  level-sensitive, active-high requests.
REQ-006 SHALL have port cycle  input  1  instruction-boundary strobe, high on an instruction's last clock.
REQ-007 SHALL have port pc  input  16  address of the next instruction; valid when cycle=1.
REQ-008 SHALL have ports ei, di, rti  input  1 each  decoded instruction strobes; sampled only when cycle=1.
REQ-009 SHALL have ports mask_wr  input  1 and mask_d  input  NSRC, which write the enable mask.
REQ-010 SHALL have port ienabled  output  1  global interrupt enable, to the register file.
REQ-011 SHALL have port istatus  output  1  high while in a handler; selects the alternate DX/DY registers.
REQ-012 SHALL have port intRA  output  16  interrupt return address.
REQ-013 SHALL have port take  output  1  one-clock fetch redirect to vector.
REQ-014 SHALL have ports vector  output  16 and ack  output  NSRC, where ack is a one-hot grant pulse.

Function
REQ-015 SHALL implement the states IDLE, ENTER and SERVICE; istatus=1 exactly in ENTER and SERVICE.
REQ-016 In IDLE with cycle=1 and ienabled=1, intRA SHALL load pc; otherwise intRA SHALL hold.
REQ-017 In IDLE, a clock with all of the following SHALL move the state to ENTER on the next edge:
- cycle=1;
- ienabled=1;
- di=0;
- (irq & mask) != 0.
REQ-018 In ENTER, take=1 and ack=one-hot(winner) for exactly one clock; ENTER SHALL then move to SERVICE unconditionally.
REQ-019 vector SHALL equal VEC_BASE + (winner << 2), computed modulo 2^16 and registered on entry to ENTER.
REQ-020 In SERVICE, irq SHALL be ignored (no nesting); rti with cycle=1 SHALL move the state to IDLE.
REQ-021 rti in IDLE SHALL be ignored.
REQ-022 ei with cycle=1 SHALL set ienabled on the next edge; ei SHALL NOT enable a take on that same boundary.
REQ-023 di with cycle=1 SHALL clear ienabled on the next edge; when di and ei coincide, di SHALL win.
REQ-024 ei and di SHALL act in any state.
REQ-025 mask_wr=1 SHALL load mask from mask_d on the next edge; mask_wr SHALL act in any state.
REQ-026 A request that is deasserted before a boundary SHALL be lost; no request latching.
REQ-027 When ENTER/SERVICE is entered, intRA SHALL hold the pc of the boundary that triggered the take.

Reset
REQ-028 nclr=0 at an edge SHALL force, from any state including mid-handler, the following:
- state=IDLE;
- ienabled=0, istatus=0, take=0;
- ack=0, intRA=0;
- vector=VEC_BASE;
- mask=all ones;
- round-robin pointer=NSRC-1.
REQ-029 No take SHALL occur on the first clock after nclr returns high.

Configuration
REQ-030 With INTCTL_RR_EN defined, the winner SHALL be the first set bit of irq&mask, searching upward from pointer+1 modulo NSRC.
REQ-031 With INTCTL_RR_EN defined, the pointer SHALL update to the winner on each grant.
REQ-032 Without INTCTL_RR_EN, the winner SHALL be the lowest set index, and no pointer SHALL exist.

Structure
REQ-033 Package intctl_pkg SHALL hold the state encoding and the VEC_STRIDE=4 constant.
REQ-034 Sub-module intctl_arb SHALL hold the combinational winner selection, both modes, and the pointer input.

Verification
REQ-035 After reset, irq=4'b0100 with ienabled=0 -> no take. Then ei, then a boundary with pc=16'h1234 -> take=1, ack=4'b0100, vector=16'hFF08, intRA=16'h1234, istatus=1.
REQ-036 Fixed mode, irq=4'b1010 -> ack=4'b0010, vector=16'hFF04. RR mode, after grant 1 and rti, irq=4'b1010 -> ack=4'b1000, vector=16'hFF0C.
REQ-037 In SERVICE, irq=4'b0001 held -> no take. rti boundary -> IDLE, and the next boundary -> ack=4'b0001, vector=16'hFF00.
REQ-038 di and irq=4'b0001 on the same boundary -> no take, ienabled=0. mask_d=4'b1110 written, then ei and irq=4'b0001 -> no take.
REQ-039 nclr=0 during SERVICE -> all REQ-028 values on the next edge. VEC_BASE=16'hFFFC with winner 1 -> vector=16'h0000.
